// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and types for the timer peripheral
package timer_pkg;

  // Bus window and register offsets within it
  localparam logic [31:0] BASE_ADDR = 32'hF100_0000;
  localparam logic [2:0]  DATA_OFS  = 3'h0;
  localparam logic [2:0]  CMD_OFS   = 3'h4;

  // Command register bit positions
  localparam int CMD_ENABLE       = 0;
  localparam int CMD_MODE         = 1;
  localparam int CMD_CLEAR        = 2;
  localparam int CMD_PRESCALE_LSB = 8;
  localparam int CMD_PRESCALE_MSB = 23;

  // Counting direction; down mode auto-reloads from the last data write
  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } timerMode_e;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides clk into one-cycle ticks every prescale+1 enabled cycles
module timer_prescaler #(
  parameter int PRESCALE_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     restart,
  input  logic [PRESCALE_BITS-1:0] prescale,
  output logic                     tick
);

  logic [PRESCALE_BITS-1:0] count;

  // A restart (any register write) suppresses the tick in the same cycle
  assign tick = enable && !restart && (count == prescale);

  // Divider count: cleared on restart, frozen while disabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/timer.sv
// rtl/timer.sv - 32-bit memory-mapped timer/counter with prescaler and auto-reload
module timer
  import timer_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int PRESCALE_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chip_select,
  input  logic             write,
  input  logic             write_command,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0]         counter;
  logic [WIDTH-1:0]         reload;
  logic                     enable;
  timerMode_e               mode;
  logic [PRESCALE_BITS-1:0] prescale;
  logic                     tick;
  logic                     cmdWrite;
  logic                     dataWrite;
  timerMode_e               newMode;
  logic                     unusedBits;

  // A command write takes precedence over a simultaneous data write
  assign cmdWrite  = chip_select && write_command;
  assign dataWrite = chip_select && write && !write_command;
  assign newMode   = timerMode_e'(data_in[CMD_MODE]);
  assign data_out  = counter;

  // Command bits outside the defined fields carry no meaning
  assign unusedBits = ^{data_in[WIDTH-1:CMD_PRESCALE_MSB+1], data_in[CMD_PRESCALE_LSB-1:CMD_CLEAR+1]};

  timer_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .restart  (cmdWrite || dataWrite),
    .prescale (prescale),
    .tick     (tick)
  );

  // Register writes, CLEAR and tick-driven counting; writes override a coincident tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter  <= '0;
      reload   <= '0;
      enable   <= 1'b0;
      mode     <= MODE_UP;
      prescale <= '0;
    end else if (cmdWrite) begin
      enable   <= data_in[CMD_ENABLE];
      mode     <= newMode;
      prescale <= data_in[CMD_PRESCALE_MSB:CMD_PRESCALE_LSB];
      // CLEAR follows the mode carried by the same command word
      if (data_in[CMD_CLEAR]) begin
        counter <= (newMode == MODE_DOWN) ? reload : '0;
      end
    end else if (dataWrite) begin
      counter <= data_in;
      reload  <= data_in;
    end else if (tick) begin
      if (mode == MODE_UP) begin
        counter <= counter + 1'b1;
      end else if (counter == '0) begin
        counter <= reload;
      end else begin
        counter <= counter - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - self-checking bench for timer with directed and randomized scenarios
module tb_timer;

  logic        clk;
  logic        reset;
  logic        chip_select;
  logic        write;
  logic        write_command;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int cmpCount = 0;
  int errCount = 0;

  // Reference model state, derived from the register-level rules
  logic [31:0] mCounter;
  logic [31:0] mReload;
  bit          mEnable;
  bit          mDown;
  int          mPeriod;
  int          mElapsed;

  timer dut (
    .clk           (clk),
    .reset         (reset),
    .chip_select   (chip_select),
    .write         (write),
    .write_command (write_command),
    .data_in       (data_in),
    .data_out      (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a tick lands on every (prescale+1)-th enabled idle cycle since the last write
  task automatic modelStep(input logic rst, input logic cs, input logic wr, input logic wc,
                           input logic [31:0] din);
    if (!rst) begin
      mCounter = 0; mReload = 0; mEnable = 0; mDown = 0; mPeriod = 1; mElapsed = 0;
    end else if (cs && wc) begin
      mEnable  = din[0];
      mDown    = din[1];
      mPeriod  = int'(din[23:8]) + 1;
      mElapsed = 0;
      if (din[2]) mCounter = mDown ? mReload : 32'd0;
    end else if (cs && wr) begin
      mCounter = din;
      mReload  = din;
      mElapsed = 0;
    end else if (mEnable) begin
      mElapsed++;
      if (mElapsed % mPeriod == 0) begin
        if (!mDown)              mCounter = mCounter + 32'd1;
        else if (mCounter == 0)  mCounter = mReload;
        else                     mCounter = mCounter - 32'd1;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle before sampling
  task automatic cycle(input logic rst, input logic cs, input logic wr, input logic wc,
                       input logic [31:0] din);
    reset = rst; chip_select = cs; write = wr; write_command = wc; data_in = din;
    @(posedge clk);
    modelStep(rst, cs, wr, wc, din);
    #1;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic dataWr(input logic [31:0] v);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, v);
  endtask

  task automatic cmdWr(input logic [31:0] v);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, v);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cmpCount++;
    if (data_out !== 32'h0) begin
      errCount++; $display("FAIL reset_value: got %h want 00000000", data_out);
    end
    for (int i = 0; i < 10; i++) begin
      idle();
      cmpCount++;
      if (data_out !== 32'h0) begin
        errCount++; $display("FAIL reset_idle[%0d]: got %h want 00000000", i, data_out);
      end
    end
  endtask

  task automatic test_up_count();
    logic [31:0] exp [3] = '{32'd6, 32'd7, 32'd8};
    dataWr(32'd5);
    cmpCount++;
    if (data_out !== 32'd5) begin
      errCount++; $display("FAIL up_load: got %h want 00000005", data_out);
    end
    cmdWr(32'h1);
    cmpCount++;
    if (data_out !== 32'd5) begin
      errCount++; $display("FAIL up_cmd_edge: got %h want 00000005", data_out);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      cmpCount++;
      if (data_out !== exp[i]) begin
        errCount++; $display("FAIL up_count[%0d]: got %h want %h", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
    dataWr(32'hFFFF_FFFE);
    cmdWr(32'h1);
    cmpCount++;
    if (data_out !== 32'hFFFF_FFFE) begin
      errCount++; $display("FAIL wrap_start: got %h want fffffffe", data_out);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      cmpCount++;
      if (data_out !== exp[i]) begin
        errCount++; $display("FAIL wrap[%0d]: got %h want %h", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_down_reload();
    logic [31:0] exp [5] = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2};
    dataWr(32'd3);
    cmdWr(32'h3);
    for (int i = 0; i < 5; i++) begin
      idle();
      cmpCount++;
      if (data_out !== exp[i]) begin
        errCount++; $display("FAIL down_reload[%0d]: got %h want %h", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_prescale();
    cmdWr(32'h0);
    dataWr(32'h0);
    cmdWr(32'h0000_0401);
    for (int k = 1; k <= 15; k++) begin
      idle();
      cmpCount++;
      if (data_out !== 32'(k / 5)) begin
        errCount++; $display("FAIL prescale[edge %0d]: got %h want %h", k, data_out, 32'(k / 5));
      end
    end
  endtask

  task automatic test_chip_select();
    dataWr(32'd10);
    cmdWr(32'h1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    cmpCount++;
    if (data_out !== 32'd11) begin
      errCount++; $display("FAIL cs_cmd_ignored: got %h want 0000000b", data_out);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h1234);
    cmpCount++;
    if (data_out !== 32'd12) begin
      errCount++; $display("FAIL cs_data_ignored: got %h want 0000000c", data_out);
    end
    // Both strobes: command wins, data word is dropped; CLEAR in up mode zeroes
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h5);
    cmpCount++;
    if (data_out !== 32'd0) begin
      errCount++; $display("FAIL both_strobes_clear: got %h want 00000000", data_out);
    end
  endtask

  task automatic test_reset_mid_count();
    idle();
    idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cmpCount++;
    if (data_out !== 32'h0) begin
      errCount++; $display("FAIL reset_mid: got %h want 00000000", data_out);
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      cmpCount++;
      if (data_out !== 32'h0) begin
        errCount++; $display("FAIL reset_stays[%0d]: got %h want 00000000", i, data_out);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] din;
    int          sel;
    int          bad = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
      din = $urandom;
      if (sel < 2) begin
        cycle(1'b0, 1'(din[0]), 1'(din[1]), 1'(din[2]), din);
      end else if (sel < 12) begin
        if (din[3]) din = 32'hFFFF_FFF0 | (din & 32'hF);
        else        din = din & 32'h7;
        cycle(1'b1, 1'($urandom_range(0, 5) != 0), 1'b1, 1'b0, din);
      end else if (sel < 20) begin
        din[23:8] = 16'($urandom_range(0, 3));
        cycle(1'b1, 1'($urandom_range(0, 5) != 0), 1'(din[31]), 1'b1, din);
      end else begin
        idle();
      end
      cmpCount++;
      if (data_out !== mCounter) begin
        errCount++;
        if (bad < 10) $display("FAIL random[%0d]: got %h want %h", i, data_out, mCounter);
        bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; chip_select = 1'b0; write = 1'b0; write_command = 1'b0; data_in = '0;
    test_reset();
    test_up_count();
    test_wrap();
    test_down_reload();
    test_prescale();
    test_chip_select();
    test_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- 32-bit memory-mapped timer/counter peripheral on the single-master CPU bus. Occupies an 8-byte window at 0xF1000000.
- Bus-side address decode (outside this block) produces `chip_select`, plus `write` for the data register (offset 0x0) and `write_command` for the command register (offset 0x4).
- Read data is the live counter value. The bus fabric registers it one cycle later.

Parameters:
- `WIDTH`, 32, counter/data width (only 32 is supported).
- `PRESCALE_BITS`, 16, width of the prescaler divider field.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `chip_select`  input  1  bus address hits the timer window.
- `write`  input  1  data-register write strobe (offset 0x0 & bus write enable).
- `write_command`  input  1  command-register write strobe (offset 0x4 & bus write enable).
- `data_in`  input  32  bus write data.
- `data_out`  output  32  current counter value, combinational from the counter register.

Behaviour:
- Reset: active-low, synchronous. Clock is `clk`. While `reset`=0 at a rising edge, the following all clear to 0:
  - counter, reload, ENABLE, MODE, PRESCALE, prescale_cnt.
  - `data_out` therefore reads 0.
- Writes are accepted only when `chip_select`=1. The strobes are ignored otherwise.
- Data write (`chip_select` & `write` & !`write_command`): counter <= `data_in` and reload <= `data_in` on that edge. prescale_cnt <= 0.
- Command write (`chip_select` & `write_command`). The command is processed whenever `write_command` is set, even if `write` is also high; the data write is dropped in that case.
  - bit0 ENABLE: 1 = count.
  - bit1 MODE: 0 = count up, free-running; 1 = count down with auto-reload.
  - bit2 CLEAR: self-clearing, not stored. Counter <= 0 in up mode, counter <= reload in down mode.
  - bits[23:8] PRESCALE.
  - Other bits are ignored.
  - Every command write also sets prescale_cnt <= 0.
- Tick generation:
  - When ENABLE=1 and no write occurs this cycle: if prescale_cnt == PRESCALE, a tick occurs and prescale_cnt <= 0; otherwise prescale_cnt increments.
  - When ENABLE=0, prescale_cnt holds and no ticks occur.
- On a tick:
  - Up mode: counter <= counter+1. It wraps 0xFFFFFFFF -> 0x00000000.
  - Down mode: if counter == 0, counter <= reload; else counter <= counter-1. With reload=0 the counter stays at 0.
- Timing:
  - With PRESCALE=0, a command write enabling the timer at edge N produces counter updates at edges N+1, N+2, ...
  - With PRESCALE=P, the first update is at edge N+1+P, then every P+1 cycles.
- Simultaneous events: a write in the same cycle as a pending tick wins. The tick is lost and the prescaler restarts.
- Read path: `data_out` = counter, with no dependence on `chip_select`. A value written at edge N is visible on `data_out` immediately after edge N.
- Reset mid-count: the counter returns to 0 and counting stops. The timer must be re-enabled by command.

Decomposition:
- Shared package `timer_pkg`:
  - Register offsets DATA_OFS=0x0, CMD_OFS=0x4, base address 0xF1000000.
  - Command bit positions CMD_ENABLE=0, CMD_MODE=1, CMD_CLEAR=2, CMD_PRESCALE_LSB=8, CMD_PRESCALE_MSB=23.
  - MODE_UP/MODE_DOWN constants.
- One natural sub-module: `timer_prescaler`.
  - Inputs: `clk`, `reset`, `enable`, `restart`, `prescale[15:0]`.
  - Output: one-cycle `tick`.
- The counter and register logic stay in `timer`.

Test Plan:
- Reset then idle 10 cycles -> `data_out` = 0x00000000, no counting.
- Data write 0x00000005 -> `data_out`=5. Command 0x1 (up, PRESCALE 0) -> `data_out` reads 6, 7, 8 on the next three edges.
- Data write 0xFFFFFFFE, command 0x1 -> `data_out` reads 0xFFFFFFFF, then 0x00000000, then 0x00000001.
- Data write 3, command 0x3 (down) -> `data_out` sequence 2, 1, 0, 3, 2 (auto-reload).
- Command 0x0000_0401 (PRESCALE=4) from counter 0 -> counter increments once every 5 cycles. First increment occurs 5 edges after the write.
- Command write with `chip_select`=0 -> ignored. Also check reset asserted mid-count -> `data_out`=0 at the next edge and stays 0.
